// File: rtl/pattern_pkg.sv
// pattern_pkg: shared definitions for the pattern step counter.
//   - xmode codes XM_ZERO/XM_ONE/XM_FOUR/XM_EIGHT
//   - direction codes DIR_UP/DIR_DOWN
//   - xmode_delta(): maps a 2-bit xmode code to its 4-bit step size
package pattern_pkg;

  localparam logic [1:0] XM_ZERO  = 2'b00;
  localparam logic [1:0] XM_ONE   = 2'b01;
  localparam logic [1:0] XM_FOUR  = 2'b10;
  localparam logic [1:0] XM_EIGHT = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [3:0] xmode_delta(input logic [1:0] xm);
    logic [3:0] d;
    case (xm)
      XM_ZERO:  d = 4'd0;
      XM_ONE:   d = 4'd1;
      XM_FOUR:  d = 4'd4;
      default:  d = 4'd8;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pattern_step_alu.sv
// pattern_step_alu: combinational step of one accumulator value.
//   base   in  WIDTH  starting value, already clamped to 0..limit
//   delta  in  4      step size (0..8)
//   dir    in  1      DIR_UP / DIR_DOWN
//   limit  in  WIDTH  upper bound of the range 0..limit
//   result out WIDTH  stepped value
//   wrap   out 1      modulo wrap occurred (or clamping, when saturating)
// Build option: define PATTERN_STEP_SATURATE_EN to clamp at 0/limit instead
// of wrapping around.
module pattern_step_alu
  import pattern_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] base,
  input  logic [3:0]       delta,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] result,
  output logic             wrap
);

  // One extra bit so base+delta and limit+1 never truncate before compare.
  logic [WIDTH:0] base_x;
  logic [WIDTH:0] delta_x;
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] r;
`ifndef PATTERN_STEP_SATURATE_EN
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
  logic [WIDTH:0] span;
  logic [WIDTH:0] d;
`endif

  always_comb begin
    base_x  = {1'b0, base};
    delta_x = {{(WIDTH-3){1'b0}}, delta};
    lim_x   = {1'b0, limit};
    r       = '0;
    wrap    = 1'b0;
`ifndef PATTERN_STEP_SATURATE_EN
    span    = lim_x + ONE;
    d       = '0;
`endif
    if (dir == DIR_UP) begin
      r = base_x + delta_x;
      if (r > lim_x) begin
        wrap = 1'b1;
`ifdef PATTERN_STEP_SATURATE_EN
        r = lim_x;
`else
        // Delta can exceed the range several times over for tiny limits.
        for (int i = 0; i < 8; i++) begin
          if (r > lim_x) r = r - span;
        end
`endif
      end
    end else begin
      if (base_x < delta_x) begin
        wrap = 1'b1;
`ifdef PATTERN_STEP_SATURATE_EN
        r = '0;
`else
        // Reduce the underflow deficit into 1..span, then fold it back.
        d = delta_x - base_x;
        for (int i = 0; i < 8; i++) begin
          if (d > span) d = d - span;
        end
        r = span - d;
`endif
      end else begin
        r = base_x - delta_x;
      end
    end
    result = r[WIDTH-1:0];
  end

endmodule

// File: rtl/pattern_step_counter.sv
// pattern_step_counter: NUM_CH independent modulo-(limit+1) accumulators.
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clear     in   synchronous clear of all channels, drops any command
//   cnt_enb   in   step channel ch_sel by the xmode delta in direction dir
//   load      in   load channel ch_sel from min(load_val, limit)
//   ch_sel    in   addressed channel; values >= NUM_CH are ignored
//   xmode     in   delta code 00/01/10/11 -> 0/1/4/8
//   dir       in   0 up, 1 down
//   load_val  in   load value
//   limit     in   shared upper bound
//   out_val   out  updated value of the last operated channel
//   out_ch    out  channel of out_val
//   out_valid out  one-cycle strobe per accepted command
//   wrap      out  strobe with out_valid when the step wrapped/saturated
// Build option: PATTERN_STEP_SATURATE_EN (see pattern_step_alu).
//
// Handshake: commands have no ready; any load/cnt_enb on a valid channel
// without clear is accepted at the edge. out_valid is a single-cycle strobe
// one cycle later with no back-pressure; out_val/out_ch hold between strobes.
module pattern_step_counter
  import pattern_pkg::*;
#(
  parameter  int WIDTH  = 12,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cnt_enb,
  input  logic             load,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [1:0]       xmode,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out_val,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_valid,
  output logic             wrap
);

  localparam int SEL_N = 1 << CH_W;
  // Bit i set when ch_sel == i addresses an existing channel.
  localparam logic [SEL_N-1:0] CH_MASK = {SEL_N{1'b1}} >> (SEL_N - NUM_CH);

  logic [WIDTH-1:0] acc [NUM_CH];
  logic [WIDTH-1:0] acc_rd;
  logic [WIDTH-1:0] raw_base;
  logic [WIDTH-1:0] base;
  logic [3:0]       delta;
  logic             cmd_hit;
  logic [WIDTH-1:0] alu_result;
  logic             alu_wrap;

  always_comb begin
    acc_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch_sel) == i) acc_rd = acc[i];
    end
    cmd_hit  = (load | cnt_enb) & CH_MASK[ch_sel];
    raw_base = load ? load_val : acc_rd;
    // A stored value above a since-lowered limit is clamped before stepping.
    base     = (raw_base > limit) ? limit : raw_base;
    delta    = cnt_enb ? xmode_delta(xmode) : 4'd0;
  end

  pattern_step_alu #(.WIDTH(WIDTH)) u_alu (
    .base   (base),
    .delta  (delta),
    .dir    (dir),
    .limit  (limit),
    .result (alu_result),
    .wrap   (alu_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear) begin
          acc[i] <= '0;
        end else if (cmd_hit && (int'(ch_sel) == i)) begin
          acc[i] <= alu_result;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val   <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (cmd_hit) begin
      out_val   <= alu_result;
      out_ch    <= ch_sel;
      out_valid <= 1'b1;
      wrap      <= alu_wrap;
    end else begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_step_counter.sv
// tb_pattern_step_counter: self-checking bench for pattern_step_counter,
// instantiated with NUM_CH = 5 so that ch_sel values 5..7 are out of range.
module tb_pattern_step_counter;

  localparam int WIDTH  = 12;
  localparam int NUM_CH = 5;
  localparam int CH_W   = 3;
  localparam int EXP_W  = 1 + CH_W + WIDTH;

  typedef struct packed {
    logic             c_clear;
    logic             c_load;
    logic             c_cnt;
    logic [2:0]       ch;
    logic [1:0]       xm;
    logic             d;
    logic [WIDTH-1:0] lv;
    logic [WIDTH-1:0] lim;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             cnt_enb;
  logic             load;
  logic [CH_W-1:0]  ch_sel;
  logic [1:0]       xmode;
  logic             dir;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] out_val;
  logic [CH_W-1:0]  out_ch;
  logic             out_valid;
  logic             wrap;

  int errors = 0;
  int checks = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] last_out;
  int m_acc [NUM_CH];
  int dtab [4] = '{0, 1, 4, 8};

  pattern_step_counter #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .cnt_enb   (cnt_enb),
    .load      (load),
    .ch_sel    (ch_sel),
    .xmode     (xmode),
    .dir       (dir),
    .load_val  (load_val),
    .limit     (limit),
    .out_val   (out_val),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- driver ----------------
  // Drives one command at a negedge, updates the reference model, pushes the
  // expected output when a strobe should follow, and returns at the next
  // negedge where that output is visible.
  task automatic send(input cmd_t c, output bit produced);
    int base, delta, v, lim;
    bit w;
    limit    = c.lim;
    clear    = c.c_clear;
    load     = c.c_load;
    cnt_enb  = c.c_cnt;
    ch_sel   = c.ch;
    xmode    = c.xm;
    dir      = c.d;
    load_val = c.lv;
    produced = 1'b0;
    lim      = int'(c.lim);
    if (c.c_clear) begin
      for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
    end else if ((c.c_load || c.c_cnt) && int'(c.ch) < NUM_CH) begin
      base  = c.c_load ? int'(c.lv) : m_acc[c.ch];
      if (base > lim) base = lim;
      delta = c.c_cnt ? dtab[c.xm] : 0;
      if (!c.d) begin
        v = base + delta;
        w = (v > lim);
`ifdef PATTERN_STEP_SATURATE_EN
        if (w) v = lim;
`else
        v = v % (lim + 1);
`endif
      end else begin
        v = base - delta;
        w = (v < 0);
`ifdef PATTERN_STEP_SATURATE_EN
        if (w) v = 0;
`else
        while (v < 0) v = v + lim + 1;
`endif
      end
      m_acc[c.ch] = v;
      exp_q.push_back({w, c.ch, WIDTH'(v)});
      produced = 1'b1;
    end
    @(negedge clk);
    clear   = 1'b0;
    load    = 1'b0;
    cnt_enb = 1'b0;
  endtask

  function automatic cmd_t mk(input bit cl, ld, ce, input int ch, xm, input bit d,
                              input int lv, lim);
    cmd_t c;
    c.c_clear = cl; c.c_load = ld; c.c_cnt = ce;
    c.ch = 3'(ch); c.xm = 2'(xm); c.d = d;
    c.lv = WIDTH'(lv); c.lim = WIDTH'(lim);
    return c;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; cnt_enb = 1'b0;
    ch_sel = '0; xmode = '0; dir = 1'b0; load_val = '0; limit = 12'd4095;
    for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (out_val !== '0) begin errors++; $display("FAIL reset_val: got %0d want 0", out_val); end
    checks++;
    if (out_ch !== '0) begin errors++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    cmd_t c [6];
    bit prod;
    logic [EXP_W-1:0] e;
    c[0] = mk(0, 1, 0, 2, 0, 0, 100, 4095);
    for (int k = 0; k < NUM_CH; k++) c[k+1] = mk(0, 0, 1, k, 0, 0, 0, 4095);
    for (int i = 0; i < 6; i++) begin
      send(c[i], prod);
      checks++;
      if (prod) begin
        e = exp_q.pop_front();
        last_out = e;
        if (out_valid !== 1'b1 || {wrap, out_ch, out_val} !== e) begin
          errors++;
          $display("FAIL load[%0d]: got v=%b w=%b ch=%0d val=%0d want v=1 w=%b ch=%0d val=%0d",
                   i, out_valid, wrap, out_ch, out_val, e[EXP_W-1], e[EXP_W-2:WIDTH], e[WIDTH-1:0]);
        end
      end else if (out_valid !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL load[%0d]: got v=%b w=%b want v=0 w=0", i, out_valid, wrap);
      end
    end
  endtask

  task automatic test_wrap();
    cmd_t c [16];
    bit prod;
    logic [EXP_W-1:0] e;
    c[0]  = mk(0, 1, 0, 0, 0, 0, 7,    9);     // ch0 = 7
    c[1]  = mk(0, 0, 1, 0, 3, 0, 0,    9);     // +8 -> 5 wrap
    c[2]  = mk(0, 1, 0, 1, 0, 0, 2,    9);     // ch1 = 2
    c[3]  = mk(0, 0, 1, 1, 2, 1, 0,    9);     // -4 -> 8 wrap
    c[4]  = mk(0, 1, 1, 2, 2, 0, 50,   4095);  // load+4 -> 54
    c[5]  = mk(0, 1, 1, 2, 2, 0, 4095, 4000);  // clamp 4000, +4 -> 3 wrap
    c[6]  = mk(0, 1, 0, 4, 0, 0, 3000, 4095);  // ch4 = 3000
    c[7]  = mk(0, 0, 1, 4, 1, 0, 0,    100);   // limit lowered: 100+1 -> 0 wrap
    c[8]  = mk(0, 0, 1, 4, 0, 1, 0,    100);   // delta 0 down, no wrap
    c[9]  = mk(0, 1, 0, 3, 0, 0, 1,    2);     // ch3 = 1
    c[10] = mk(0, 0, 1, 3, 3, 0, 0,    2);     // 1+8 over range 3 -> 0
    c[11] = mk(0, 0, 1, 3, 3, 1, 0,    2);     // 0-8 -> 1
    c[12] = mk(0, 0, 1, 0, 1, 0, 0,    0);     // limit 0 up
    c[13] = mk(0, 0, 1, 0, 3, 1, 0,    0);     // limit 0 down
    c[14] = mk(0, 0, 1, 0, 0, 0, 0,    0);     // limit 0 delta 0
    c[15] = mk(0, 1, 0, 1, 0, 0, 7,    0);     // load clamps to 0
    for (int i = 0; i < 16; i++) begin
      send(c[i], prod);
      checks++;
      if (prod) begin
        e = exp_q.pop_front();
        last_out = e;
        if (out_valid !== 1'b1 || {wrap, out_ch, out_val} !== e) begin
          errors++;
          $display("FAIL wrap[%0d]: got v=%b w=%b ch=%0d val=%0d want v=1 w=%b ch=%0d val=%0d",
                   i, out_valid, wrap, out_ch, out_val, e[EXP_W-1], e[EXP_W-2:WIDTH], e[WIDTH-1:0]);
        end
      end else if (out_valid !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL wrap[%0d]: got v=%b w=%b want v=0 w=0", i, out_valid, wrap);
      end
    end
  endtask

  task automatic test_back_to_back();
    cmd_t c [5];
    bit prod;
    logic [EXP_W-1:0] e;
    c[0] = mk(1, 0, 0, 0, 0, 0, 0, 4095);  // clear everything
    c[1] = mk(0, 0, 1, 3, 1, 0, 0, 4095);  // -> 1
    c[2] = mk(0, 0, 1, 3, 1, 0, 0, 4095);  // -> 2
    c[3] = mk(1, 0, 1, 3, 1, 0, 0, 4095);  // clear drops this step
    c[4] = mk(0, 0, 1, 3, 1, 0, 0, 4095);  // -> 1
    for (int i = 0; i < 5; i++) begin
      send(c[i], prod);
      checks++;
      if (prod) begin
        e = exp_q.pop_front();
        last_out = e;
        if (out_valid !== 1'b1 || {wrap, out_ch, out_val} !== e) begin
          errors++;
          $display("FAIL b2b[%0d]: got v=%b w=%b ch=%0d val=%0d want v=1 w=%b ch=%0d val=%0d",
                   i, out_valid, wrap, out_ch, out_val, e[EXP_W-1], e[EXP_W-2:WIDTH], e[WIDTH-1:0]);
        end
      end else if (out_valid !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b w=%b want v=0 w=0", i, out_valid, wrap);
      end
    end
  endtask

  task automatic test_invalid_ch();
    cmd_t c [13];
    bit prod;
    logic [EXP_W-1:0] e;
    for (int k = 0; k < NUM_CH; k++) c[k] = mk(0, 1, 0, k, 0, 0, 10 + k, 4095);
    c[5] = mk(0, 1, 0, 5, 0, 0, 77, 4095);
    c[6] = mk(0, 1, 1, 6, 2, 0, 88, 4095);
    c[7] = mk(0, 0, 1, 7, 3, 1, 0,  4095);
    for (int k = 0; k < NUM_CH; k++) c[k+8] = mk(0, 0, 1, k, 0, 0, 0, 4095);
    for (int i = 0; i < 13; i++) begin
      send(c[i], prod);
      checks++;
      if (prod) begin
        e = exp_q.pop_front();
        last_out = e;
        if (out_valid !== 1'b1 || {wrap, out_ch, out_val} !== e) begin
          errors++;
          $display("FAIL badch[%0d]: got v=%b w=%b ch=%0d val=%0d want v=1 w=%b ch=%0d val=%0d",
                   i, out_valid, wrap, out_ch, out_val, e[EXP_W-1], e[EXP_W-2:WIDTH], e[WIDTH-1:0]);
        end
      end else if (out_valid !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL badch[%0d]: got v=%b w=%b want v=0 w=0", i, out_valid, wrap);
      end
    end
  endtask

  task automatic test_idle_hold();
    bit prod;
    logic [EXP_W-1:0] e;
    send(mk(0, 0, 1, 1, 3, 1, 0, 9), prod);   // ch1 = 11 -> clamp 9 - 8 = 1
    checks++;
    e = exp_q.pop_front();
    last_out = e;
    if (out_valid !== 1'b1 || {wrap, out_ch, out_val} !== e) begin
      errors++;
      $display("FAIL idle_cmd: got v=%b w=%b ch=%0d val=%0d want v=1 w=%b ch=%0d val=%0d",
               out_valid, wrap, out_ch, out_val, e[EXP_W-1], e[EXP_W-2:WIDTH], e[WIDTH-1:0]);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || wrap !== 1'b0 || out_ch !== last_out[EXP_W-2:WIDTH]
          || out_val !== last_out[WIDTH-1:0]) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got v=%b w=%b ch=%0d val=%0d want v=0 w=0 ch=%0d val=%0d",
                 i, out_valid, wrap, out_ch, out_val, last_out[EXP_W-2:WIDTH], last_out[WIDTH-1:0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit prod;
    logic [EXP_W-1:0] e;
    send(mk(0, 1, 0, 2, 0, 0, 100, 4095), prod);
    checks++;
    e = exp_q.pop_front();
    if (out_valid !== 1'b1 || {wrap, out_ch, out_val} !== e) begin
      errors++;
      $display("FAIL mrst_load: got v=%b ch=%0d val=%0d want v=1 ch=%0d val=%0d",
               out_valid, out_ch, out_val, e[EXP_W-2:WIDTH], e[WIDTH-1:0]);
    end
    // Step in flight, then assert reset asynchronously just after the edge.
    cnt_enb = 1'b1; ch_sel = 3'd2; xmode = 2'b01; dir = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || wrap !== 1'b0 || out_val !== '0 || out_ch !== '0) begin
      errors++;
      $display("FAIL mrst_async: got v=%b w=%b ch=%0d val=%0d want all 0",
               out_valid, wrap, out_ch, out_val);
    end
    cnt_enb = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(mk(0, 0, 1, 2, 0, 0, 0, 4095), prod);
    checks++;
    e = exp_q.pop_front();
    last_out = e;
    if (out_valid !== 1'b1 || {wrap, out_ch, out_val} !== e) begin
      errors++;
      $display("FAIL mrst_after: got v=%b w=%b ch=%0d val=%0d want v=1 w=%b ch=%0d val=%0d",
               out_valid, wrap, out_ch, out_val, e[EXP_W-1], e[EXP_W-2:WIDTH], e[WIDTH-1:0]);
    end
  endtask

  task automatic test_random();
    int lims [5] = '{0, 2, 9, 4095, 1000};
    int lim;
    bit prod;
    cmd_t c;
    logic [EXP_W-1:0] e;
    lim = 9;
    for (int i = 0; i < 120; i++) begin
      if (i % 15 == 0) lim = lims[$urandom_range(0, 4)];
      c = mk($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 4095), lim);
      send(c, prod);
      checks++;
      if (prod) begin
        e = exp_q.pop_front();
        last_out = e;
        if (out_valid !== 1'b1 || {wrap, out_ch, out_val} !== e) begin
          errors++;
          $display("FAIL rand[%0d]: got v=%b w=%b ch=%0d val=%0d want v=1 w=%b ch=%0d val=%0d",
                   i, out_valid, wrap, out_ch, out_val, e[EXP_W-1], e[EXP_W-2:WIDTH], e[WIDTH-1:0]);
        end
      end else if (out_valid !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL rand[%0d]: got v=%b w=%b want v=0 w=0", i, out_valid, wrap);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    last_out = '0;
    test_reset();
    test_load();
    test_wrap();
    test_back_to_back();
    test_invalid_ch();
    test_idle_hold();
    test_mid_reset();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
